// File: rtl/boot_frame_writer.sv
// Write-side frame sequencer for the bootloader UART-to-CPU FIFO (clk_w domain).
// Parses SYNC/LEN/payload/CHK frames and streams payload bytes through a small skid buffer.
module boot_frame_writer #(
   parameter logic [7:0] SYNC_BYTE      = 8'hA5,
   parameter int         MAX_LEN        = 4096,
   parameter int         TIMEOUT_CYCLES = 1000000,
   parameter int         HOLD_DEPTH     = 2
) (
   input  logic        clk_w,
   input  logic        rst_n_w,
   input  logic        enable,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   input  logic        rx_err,
   input  logic        fifo_full,
   output logic        fifo_wr_en,
   output logic [7:0]  fifo_wr_data,
   output logic        busy,
   output logic        frame_done,
   output logic        frame_err,
   output logic [2:0]  err_code,
   output logic [15:0] payload_len
);

   // state   | meaning
   // IDLE    | waiting for SYNC_BYTE while enable is high
   // LEN_LO  | expecting low byte of LEN
   // LEN_HI  | expecting high byte of LEN, range-checked here
   // PAYLOAD | pushing payload bytes into the skid buffer
   // CHECK   | expecting the XOR checksum byte
   // DRAIN   | waiting for the skid buffer to empty before frame_done
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LEN_LO,
      ST_LEN_HI,
      ST_PAYLOAD,
      ST_CHECK,
      ST_DRAIN
   } state_t;

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int PW = (HOLD_DEPTH > 1) ? $clog2(HOLD_DEPTH) : 1;
   localparam int CW = $clog2(HOLD_DEPTH + 1);

   localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [CW-1:0] SKID_FULL = CW'(HOLD_DEPTH);
   localparam logic [PW-1:0] PTR_LAST  = PW'(HOLD_DEPTH - 1);
   localparam logic [15:0]   MAX_LEN_W = 16'(MAX_LEN);

   localparam logic [2:0] ERR_NONE    = 3'd0;
   localparam logic [2:0] ERR_LEN     = 3'd1;
   localparam logic [2:0] ERR_CHK     = 3'd2;
   localparam logic [2:0] ERR_TIMEOUT = 3'd3;
   localparam logic [2:0] ERR_OVF     = 3'd4;
   localparam logic [2:0] ERR_RXERR   = 3'd5;

   state_t        state_q;
   logic [7:0]    len_lo_q;
   logic [15:0]   remaining_q;
   logic [7:0]    chk_q;
   logic [TW-1:0] tmr_q;
   logic          busy_q;
   logic          frame_done_q;
   logic          frame_err_q;
   logic [2:0]    err_code_q;
   logic [15:0]   payload_len_q;

   logic [7:0]    skid_q [HOLD_DEPTH];
   logic [PW-1:0] rd_q;
   logic [PW-1:0] wr_q;
   logic [CW-1:0] cnt_q;

   logic          rx_ok;
   logic          timed_state;
   logic          pop;
   logic          skid_full;
   logic [15:0]   len_d;
   logic          len_bad;
   logic          chk_bad;
   logic          ovf;
   logic          timeout_hit;
   logic          rxerr_hit;
   logic          push_d;
   logic          abort_d;
   logic [2:0]    abort_code_d;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PTR_LAST) ? '0 : p + PW'(1);
   endfunction

   assign pop          = (cnt_q != '0) && !fifo_full;
   assign fifo_wr_en   = pop;
   assign fifo_wr_data = skid_q[rd_q];
   assign skid_full    = (cnt_q == SKID_FULL);

   always_comb begin
      rx_ok        = rx_valid && !rx_err;
      timed_state  = (state_q == ST_LEN_LO) || (state_q == ST_LEN_HI) ||
                     (state_q == ST_PAYLOAD) || (state_q == ST_CHECK);
      len_d        = {rx_data, len_lo_q};
      len_bad      = (len_d == 16'd0) || (len_d > MAX_LEN_W);
      rxerr_hit    = rx_valid && rx_err && (state_q != ST_IDLE);
      ovf          = (state_q == ST_PAYLOAD) && rx_ok && skid_full && !pop;
      timeout_hit  = !rx_valid && timed_state && (tmr_q == TMO_LAST);
      chk_bad      = (state_q == ST_CHECK) && rx_ok && (rx_data != chk_q);
      push_d       = (state_q == ST_PAYLOAD) && rx_ok && !ovf;
      abort_d      = 1'b1;
      abort_code_d = ERR_NONE;
      // Priority: RXERR > OVF > LEN/CHK; timeout can only fire with rx_valid low.
      if (rxerr_hit)                                     abort_code_d = ERR_RXERR;
      else if (ovf)                                      abort_code_d = ERR_OVF;
      else if ((state_q == ST_LEN_HI) && rx_ok && len_bad) abort_code_d = ERR_LEN;
      else if (chk_bad)                                  abort_code_d = ERR_CHK;
      else if (timeout_hit)                              abort_code_d = ERR_TIMEOUT;
      else                                               abort_d      = 1'b0;
   end

   always_ff @(posedge clk_w or negedge rst_n_w) begin
      if (!rst_n_w) begin
         state_q       <= ST_IDLE;
         len_lo_q      <= '0;
         remaining_q   <= '0;
         chk_q         <= '0;
         tmr_q         <= '0;
         busy_q        <= 1'b0;
         frame_done_q  <= 1'b0;
         frame_err_q   <= 1'b0;
         err_code_q    <= ERR_NONE;
         payload_len_q <= '0;
      end else begin
         frame_done_q <= 1'b0;
         frame_err_q  <= 1'b0;

         if (rx_valid || !timed_state) tmr_q <= '0;
         else                          tmr_q <= tmr_q + TW'(1);

         if ((state_q == ST_LEN_HI) && rx_ok) payload_len_q <= len_d;

         if (abort_d) begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b1;
            err_code_q  <= abort_code_d;
            tmr_q       <= '0;
         end else begin
            unique case (state_q)
               ST_IDLE: begin
                  if (rx_ok && enable && (rx_data == SYNC_BYTE)) begin
                     state_q    <= ST_LEN_LO;
                     busy_q     <= 1'b1;
                     err_code_q <= ERR_NONE;
                  end
               end
               ST_LEN_LO: begin
                  if (rx_ok) begin
                     len_lo_q <= rx_data;
                     state_q  <= ST_LEN_HI;
                  end
               end
               ST_LEN_HI: begin
                  if (rx_ok) begin
                     remaining_q <= len_d;
                     chk_q       <= '0;
                     state_q     <= ST_PAYLOAD;
                  end
               end
               ST_PAYLOAD: begin
                  if (rx_ok) begin
                     chk_q       <= chk_q ^ rx_data;
                     remaining_q <= remaining_q - 16'd1;
                     if (remaining_q == 16'd1) state_q <= ST_CHECK;
                  end
               end
               ST_CHECK: begin
                  if (rx_ok) state_q <= ST_DRAIN;
               end
               ST_DRAIN: begin
                  if (cnt_q == '0) begin
                     frame_done_q <= 1'b1;
                     busy_q       <= 1'b0;
                     state_q      <= ST_IDLE;
                  end
               end
               default: begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end
            endcase
         end
      end
   end

   // An abort discards unwritten bytes; a pop on that same edge still completes its write.
   always_ff @(posedge clk_w or negedge rst_n_w) begin
      if (!rst_n_w) begin
         for (int i = 0; i < HOLD_DEPTH; i++) skid_q[i] <= '0;
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
      end else if (abort_d) begin
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (push_d) begin
            skid_q[wr_q] <= rx_data;
            wr_q         <= ptr_inc(wr_q);
         end
         if (pop) rd_q <= ptr_inc(rd_q);
         unique case ({push_d, pop})
            2'b10:   cnt_q <= cnt_q + CW'(1);
            2'b01:   cnt_q <= cnt_q - CW'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   assign busy        = busy_q;
   assign frame_done  = frame_done_q;
   assign frame_err   = frame_err_q;
   assign err_code    = err_code_q;
   assign payload_len = payload_len_q;

endmodule

// File: tb/tb_boot_frame_writer.sv
// Scoreboard bench for boot_frame_writer: stimulus queues expected FIFO writes and
// done/error events; a negedge monitor pops and compares them as the DUT presents them.
module tb_boot_frame_writer;

   logic        clk_w = 1'b0;
   logic        rst_n_w = 1'b0;
   logic        enable = 1'b0;
   logic        rx_valid = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_err = 1'b0;
   logic        fifo_full = 1'b0;
   logic        fifo_wr_en;
   logic [7:0]  fifo_wr_data;
   logic        busy;
   logic        frame_done;
   logic        frame_err;
   logic [2:0]  err_code;
   logic [15:0] payload_len;

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0] exp_wr_q [$];
   int         exp_ev_q [$];

   localparam int EV_DONE = 16;

   boot_frame_writer #(
      .SYNC_BYTE(8'hA5),
      .MAX_LEN(4096),
      .TIMEOUT_CYCLES(16),
      .HOLD_DEPTH(2)
   ) dut (
      .clk_w(clk_w),
      .rst_n_w(rst_n_w),
      .enable(enable),
      .rx_valid(rx_valid),
      .rx_data(rx_data),
      .rx_err(rx_err),
      .fifo_full(fifo_full),
      .fifo_wr_en(fifo_wr_en),
      .fifo_wr_data(fifo_wr_data),
      .busy(busy),
      .frame_done(frame_done),
      .frame_err(frame_err),
      .err_code(err_code),
      .payload_len(payload_len)
   );

   always #5 clk_w = ~clk_w;

   function automatic int ev_err(input int code);
      return 8 + code;
   endfunction

   always @(negedge clk_w) begin
      if (rst_n_w) begin
         if (fifo_wr_en) begin
            n_tests++;
            if (exp_wr_q.size() == 0) begin
               n_fail++;
               $display("FAIL write_unexpected: got %h, expected no write", fifo_wr_data);
            end else begin
               logic [7:0] e;
               e = exp_wr_q.pop_front();
               if (fifo_wr_data !== e) begin
                  n_fail++;
                  $display("FAIL write_data: got %h, expected %h", fifo_wr_data, e);
               end
            end
         end
         if (frame_done || frame_err) begin
            int act;
            act = {27'd0, frame_done, frame_err, err_code};
            n_tests++;
            if (exp_ev_q.size() == 0) begin
               n_fail++;
               $display("FAIL event_unexpected: got done=%0b err=%0b code=%0d, expected none",
                        frame_done, frame_err, err_code);
            end else begin
               int e;
               e = exp_ev_q.pop_front();
               if (act != e) begin
                  n_fail++;
                  $display("FAIL event: got done=%0b err=%0b code=%0d, expected done=%0b err=%0b code=%0d",
                           frame_done, frame_err, err_code, e[4], e[3], e[2:0]);
               end
            end
         end
      end
   end

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic gap(input int n);
      repeat (n) begin
         @(posedge clk_w);
         #1;
      end
   endtask

   task automatic send_raw(input logic [7:0] b, input logic e = 1'b0);
      rx_valid = 1'b1;
      rx_data  = b;
      rx_err   = e;
      @(posedge clk_w);
      #1;
      rx_valid = 1'b0;
      rx_err   = 1'b0;
   endtask

   task automatic send(input logic [7:0] b, input logic e = 1'b0);
      send_raw(b, e);
      gap(2);
   endtask

   task automatic send_payload(input logic [7:0] b);
      exp_wr_q.push_back(b);
      send(b);
   endtask

   initial begin
      #1;
      check("reset_busy", int'(busy), 0);
      check("reset_wr_en", int'(fifo_wr_en), 0);
      check("reset_done_err", int'({frame_done, frame_err}), 0);
      check("reset_err_code", int'(err_code), 0);
      check("reset_payload_len", int'(payload_len), 0);
      check("reset_wr_data", int'(fifo_wr_data), 0);
      gap(2);
      rst_n_w = 1'b1;
      gap(2);

      // enable low in IDLE: SYNC ignored
      send(8'hA5);
      check("disabled_sync_ignored", int'(busy), 0);

      // test 1: good frame
      enable = 1'b1;
      send(8'hA5);
      check("sync_busy", int'(busy), 1);
      send(8'h03);
      send(8'h00);
      check("t1_payload_len", int'(payload_len), 3);
      send_payload(8'h11);
      send_payload(8'h22);
      send_payload(8'h33);
      exp_ev_q.push_back(EV_DONE);
      send(8'h00);
      gap(3);
      check("t1_err_code", int'(err_code), 0);
      check("t1_idle", int'(busy), 0);

      // test 2: bad checksum
      send(8'hA5); send(8'h03); send(8'h00);
      send_payload(8'h11);
      send_payload(8'h22);
      send_payload(8'h33);
      exp_ev_q.push_back(ev_err(2));
      send(8'h01);
      gap(3);
      check("t2_err_code", int'(err_code), 2);
      check("t2_idle", int'(busy), 0);

      // test 3: LEN 0 and LEN 4097, then a good frame with enable dropped mid-frame
      exp_ev_q.push_back(ev_err(1));
      send(8'hA5); send(8'h00); send(8'h00);
      check("t3_len0_code", int'(err_code), 1);
      exp_ev_q.push_back(ev_err(1));
      send(8'hA5); send(8'h01); send(8'h10);
      check("t3_len4097_code", int'(err_code), 1);
      check("t3_len4097_payload_len", int'(payload_len), 4097);
      send(8'hA5);
      check("t3_err_cleared_on_sync", int'(err_code), 0);
      enable = 1'b0;
      send(8'h01); send(8'h00);
      send_payload(8'h7E);
      exp_ev_q.push_back(EV_DONE);
      send(8'h7E);
      gap(3);
      enable = 1'b1;
      check("t3_payload_len", int'(payload_len), 1);

      // LEN == MAX_LEN is accepted: stall afterwards yields TIMEOUT, not LEN
      send(8'hA5); send(8'h00); send_raw(8'h10);
      check("max_len_payload_len", int'(payload_len), 4096);
      check("max_len_busy", int'(busy), 1);
      exp_ev_q.push_back(ev_err(3));
      gap(20);
      check("max_len_timeout_code", int'(err_code), 3);

      // test 4a: overflow with fifo_full held
      fifo_full = 1'b1;
      send(8'hA5); send(8'h03); send(8'h00);
      send(8'hC1);
      send(8'hC2);
      exp_ev_q.push_back(ev_err(4));
      send(8'hC3);
      check("t4_ovf_code", int'(err_code), 4);
      fifo_full = 1'b0;
      gap(4);
      check("t4_flushed_no_wr", int'(fifo_wr_en), 0);

      // test 4b: fifo_full released after two bytes
      fifo_full = 1'b1;
      send(8'hA5); send(8'h02); send(8'h00);
      exp_wr_q.push_back(8'h5A);
      send(8'h5A);
      exp_wr_q.push_back(8'hC3);
      send(8'hC3);
      fifo_full = 1'b0;
      gap(3);
      exp_ev_q.push_back(EV_DONE);
      send(8'h99);
      gap(3);
      check("t4b_err_code", int'(err_code), 0);

      // test 5: 16-cycle stall times out, 15-cycle stall does not
      send(8'hA5); send(8'h02); send_raw(8'h00);
      exp_ev_q.push_back(ev_err(3));
      gap(16);
      gap(1);
      check("t5_timeout_code", int'(err_code), 3);
      check("t5_timeout_idle", int'(busy), 0);
      send(8'hA5); send(8'h02); send_raw(8'h00);
      gap(15);
      check("t5_no_timeout_busy", int'(busy), 1);
      send_payload(8'h10);
      send_payload(8'h20);
      exp_ev_q.push_back(EV_DONE);
      send(8'h30);
      gap(3);
      check("t5_no_timeout_code", int'(err_code), 0);

      // rx_err inside a frame
      send(8'hA5); send(8'h02); send(8'h00);
      send_payload(8'h44);
      exp_ev_q.push_back(ev_err(5));
      send(8'h55, 1'b1);
      gap(2);
      check("rxerr_code", int'(err_code), 5);

      // test 6: reset mid-payload with bytes held in the skid buffer
      fifo_full = 1'b1;
      send(8'hA5); send(8'h05); send(8'h00);
      send(8'h01); send(8'h02);
      rst_n_w   = 1'b0;
      fifo_full = 1'b0;
      #2;
      check("t6_rst_busy", int'(busy), 0);
      check("t6_rst_wr_en", int'(fifo_wr_en), 0);
      check("t6_rst_pulses", int'({frame_done, frame_err}), 0);
      @(posedge clk_w);
      #1;
      rst_n_w = 1'b1;
      gap(3);
      send(8'hA5); send(8'h02); send(8'h00);
      send_payload(8'hAB);
      send_payload(8'hCD);
      exp_ev_q.push_back(EV_DONE);
      send(8'h66);
      gap(4);
      check("t6_payload_len", int'(payload_len), 2);
      check("t6_idle", int'(busy), 0);

      gap(5);
      check("writes_outstanding", exp_wr_q.size(), 0);
      check("events_outstanding", exp_ev_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
